pipo_bidir_shift_register: RTL and testbench



---
 rtl/pipo_bidir_shift_register.sv | 68 ++++++
 tb/tb_pipo_bidir_shift_register.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipo_bidir_shift_register.sv
// rtl/pipo_bidir_shift_register.sv - PIPO bidirectional shift register (hold/right/left/load, sync clear)
// Optional Sticky output (OR of bits shifted out on the right) compiled in with PIPO_STICKY_EN.
module pipo_bidir_shift_register #(
   parameter int WIDTH = 24
) (
   input  logic             Clk,
   input  logic             Clear,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] I,
`ifdef PIPO_STICKY_EN
   output logic             Sticky,
`endif
   output logic [WIDTH-1:0] A
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] a_q, a_d;

   always_comb begin
      a_d = a_q;
      unique case (S)
         MODE_HOLD:  a_d = a_q;
         MODE_RIGHT: a_d = {1'b0, a_q[WIDTH-1:1]};
         MODE_LEFT:  a_d = {a_q[WIDTH-2:0], 1'b0};
         MODE_LOAD:  a_d = I;
         default:    a_d = a_q;
      endcase
   end

   // Clear wins over any mode selected in the same cycle.
   always_ff @(posedge Clk) begin
      if (Clear) begin
         a_q <= '0;
      end else begin
         a_q <= a_d;
      end
   end

   assign A = a_q;

`ifdef PIPO_STICKY_EN
   logic sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q;
      unique case (S)
         MODE_RIGHT: sticky_d = sticky_q | a_q[0];
         MODE_LOAD:  sticky_d = 1'b0;
         default:    sticky_d = sticky_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clear) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign Sticky = sticky_q;
`endif

endmodule

// File: tb/tb_pipo_bidir_shift_register.sv
// tb/tb_pipo_bidir_shift_register.sv - directed plus random bench for pipo_bidir_shift_register
// Reference model is arithmetic on an integer (divide/multiply by two modulo 2^WIDTH).
module tb_pipo_bidir_shift_register;

   localparam int WIDTH = 24;
   localparam longint unsigned MODULUS = 64'd1 << WIDTH;

   logic             Clk;
   logic             Clear;
   logic [1:0]       S;
   logic [WIDTH-1:0] I;
   logic [WIDTH-1:0] A;
`ifdef PIPO_STICKY_EN
   logic             Sticky;
`endif

   int vectors;
   int miscompares;

   longint unsigned model_val;
   bit              model_sticky;

   pipo_bidir_shift_register #(.WIDTH(WIDTH)) dut (
      .Clk    (Clk),
      .Clear  (Clear),
      .S      (S),
      .I      (I),
`ifdef PIPO_STICKY_EN
      .Sticky (Sticky),
`endif
      .A      (A)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag);
      logic [WIDTH-1:0] exp_a;
      exp_a = model_val[WIDTH-1:0];
      vectors++;
      assert (A === exp_a) else begin
         miscompares++;
         $error("FAIL %s: A observed=%h expected=%h", tag, A, exp_a);
      end
`ifdef PIPO_STICKY_EN
      vectors++;
      assert (Sticky === model_sticky) else begin
         miscompares++;
         $error("FAIL %s_sticky: observed=%b expected=%b", tag, Sticky, model_sticky);
      end
`endif
   endtask

   // Apply one cycle of stimulus, advance the model, check #1 after the edge.
   task automatic step(input string tag, input bit clr, input bit [1:0] s, input bit [WIDTH-1:0] i);
      Clear = clr;
      S     = s;
      I     = i;
      @(posedge Clk);
      if (clr) begin
         model_val    = 0;
         model_sticky = 1'b0;
      end else begin
         case (s)
            2'd1: begin
               model_sticky = model_sticky | (model_val % 2 == 1);
               model_val    = model_val / 2;
            end
            2'd2: model_val = (model_val * 2) % MODULUS;
            2'd3: begin
               model_val    = longint'(i);
               model_sticky = 1'b0;
            end
            default: ;
         endcase
      end
      #1;
      check(tag);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      model_val    = 0;
      model_sticky = 1'b0;
      Clear = 1'b0;
      S     = 2'b00;
      I     = '0;
      @(negedge Clk);

      step("reset", 1'b1, 2'b11, 24'hABCDEF);
      step("reset_hold", 1'b0, 2'b00, 24'h123456);

      step("load", 1'b0, 2'b11, 24'h060002);
      step("shr1", 1'b0, 2'b01, 24'hFFFFFF);
      step("shr2", 1'b0, 2'b01, 24'h000000);
      step("hold", 1'b0, 2'b00, 24'h555555);
      step("shl1", 1'b0, 2'b10, 24'hAAAAAA);

      step("clear_prio", 1'b1, 2'b11, 24'hFFFFFF);
      step("load_after_clear", 1'b0, 2'b11, 24'hFFFFFF);

      step("load_msb", 1'b0, 2'b11, 24'h800000);
      for (int k = 1; k <= WIDTH; k++) begin
         step($sformatf("drain_r%0d", k), 1'b0, 2'b01, 24'($urandom));
      end
      step("drain_r25", 1'b0, 2'b01, 24'($urandom));
      step("zero_shl", 1'b0, 2'b10, 24'($urandom));

      step("load_lsb", 1'b0, 2'b11, 24'h000001);
      step("shl_lsb", 1'b0, 2'b10, 24'h000000);
      step("load_msb2", 1'b0, 2'b11, 24'h800000);
      step("shl_msb_out", 1'b0, 2'b10, 24'h000000);

      for (int n = 0; n < 400; n++) begin
         step($sformatf("rand%0d", n), ($urandom_range(0, 19) == 0), 2'($urandom), 24'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
